// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: verdict states and trace entries.
// Optional X detection is enabled with STORE_CHECKER_XCHECK_EN.
package store_checker_pkg;

    localparam int STORE_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } trace_t;

endpackage

// File: rtl/store_checker_if.sv
// Store stream from the processor top plus the checker's verdict/trace view.
// Master drives the store bus and trace pops; slave is the checker.
interface store_checker_if #(
    parameter int TRACE_DEPTH = 8
);
    import store_checker_pkg::*;

    localparam int CW = $clog2(TRACE_DEPTH) + 1;

    logic                   MemWrite;
    logic [31:0]            DataAdr;
    logic [31:0]            WriteData;
    logic                   trace_rd;
    logic                   trace_valid;
    logic [31:0]            trace_adr;
    logic [31:0]            trace_data;
    logic [CW-1:0]          trace_count;
    logic                   trace_ovf;
    logic [STORE_CNT_W-1:0] store_count;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic                   timeout;

    modport master (
        output MemWrite, DataAdr, WriteData, trace_rd,
        input  trace_valid, trace_adr, trace_data, trace_count,
        input  trace_ovf, store_count, done, pass, fail, timeout
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, trace_rd,
        output trace_valid, trace_adr, trace_data, trace_count,
        output trace_ovf, store_count, done, pass, fail, timeout
    );

endinterface

// File: rtl/store_checker_trace_fifo.sv
// First-word fall-through trace FIFO with sticky overflow on dropped pushes.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module store_checker_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign empty  = (cnt == '0);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign doPush = push && (!full || doPop);
    assign count  = cnt;
    assign dout   = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            cnt <= cnt + (AW+1)'(doPush) - (AW+1)'(doPop);
            if (push && !doPush) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/store_checker.sv
// Sticky PASS/FAIL/TIMEOUT monitor on the processor's data-memory store stream.
// Define STORE_CHECKER_XCHECK_EN to fail on X/Z store address or data.
module store_checker
    import store_checker_pkg::*;
#(
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd7,
    parameter logic [31:0] ALLOW_ADR   = 32'd96,
    parameter int          TIMEOUT_CYC = 1000,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    store_checker_if.slave bus
);
    localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int            CW    = $clog2(TRACE_DEPTH) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    state_t                 state;
    state_t                 nextState;
    logic [TW-1:0]          tmr;
    logic [STORE_CNT_W-1:0] storeCnt;
    logic                   accept;
    logic                   passHit;
    logic                   allowHit;
    logic                   xBad;
    logic                   tmrHit;
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic [CW-1:0]          fifoCount;
    trace_t                 entry;
    trace_t                 head;

    assign passHit  = (bus.DataAdr == PASS_ADR) && (bus.WriteData == PASS_DATA);
    assign allowHit = (bus.DataAdr == ALLOW_ADR);
    // Saturates at TLAST so a late allowed store cannot skip the timeout
    assign tmrHit   = (tmr == TLAST);
    assign accept   = bus.MemWrite && (state == RUN);
    assign entry    = '{adr: bus.DataAdr, data: bus.WriteData};

`ifdef STORE_CHECKER_XCHECK_EN
    assign xBad = $isunknown({bus.DataAdr, bus.WriteData});
`else
    assign xBad = 1'b0;
`endif

    always_comb begin
        nextState = state;
        unique case (state)
            RUN: begin
                if (bus.MemWrite) begin
                    if (xBad)          nextState = FAIL;
                    else if (passHit)  nextState = PASS;
                    else if (!allowHit) nextState = FAIL;
                end else if (tmrHit) begin
                    nextState = TIMEOUT;
                end
            end
            default: nextState = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            tmr      <= '0;
            storeCnt <= '0;
        end else begin
            state <= nextState;
            if (state == RUN && !tmrHit) tmr <= tmr + 1'b1;
            if (accept && storeCnt != '1) storeCnt <= storeCnt + 1'b1;
        end
    end

    store_checker_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH ($bits(trace_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (bus.trace_rd),
        .din   (entry),
        .dout  (head),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount),
        .ovf   (bus.trace_ovf)
    );

    assert property (@(posedge clk) disable iff (reset)
        fifoFull == (fifoCount == CW'(TRACE_DEPTH)));

    assign bus.trace_valid = !fifoEmpty;
    assign bus.trace_adr   = head.adr;
    assign bus.trace_data  = head.data;
    assign bus.trace_count = fifoCount;
    assign bus.store_count = storeCnt;
    assign bus.pass        = (state == PASS);
    assign bus.fail        = (state == FAIL);
    assign bus.timeout     = (state == TIMEOUT);
    assign bus.done        = (state != RUN);

endmodule

// File: tb/tb_store_checker.sv
// Randomized + directed bench for store_checker against a queue-based model.
// Covers STORE_CHECKER_XCHECK_EN when the macro is defined.
module tb_store_checker;
    localparam int TO    = 20;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    store_checker_if #(.TRACE_DEPTH(DEPTH)) bus();

    store_checker #(
        .TIMEOUT_CYC (TO),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    bit          mPass, mFail, mTo, mOvf;
    int          mCnt, mCyc;
    logic [63:0] mQ[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mReset();
        mPass = 0; mFail = 0; mTo = 0; mOvf = 0;
        mCnt = 0; mCyc = 0;
        mQ.delete();
    endtask

    task automatic mStep(input bit mw, input logic [31:0] a, input logic [31:0] d,
                         input bit rd, input bit xb);
        bit running;
        bit push;
        running = !(mPass || mFail || mTo);
        push = running && mw;
        if (running) begin
            if (mw) begin
                if (mCnt < 65535) mCnt++;
                if (xb) mFail = 1;
                else if (a == 100 && d == 7) mPass = 1;
                else if (a != 96) mFail = 1;
            end else if (mCyc >= TO - 1) begin
                mTo = 1;
            end
            mCyc++;
        end
        if (rd && mQ.size() > 0) void'(mQ.pop_front());
        if (push) begin
            if (mQ.size() < DEPTH) mQ.push_back({a, d});
            else mOvf = 1;
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            chk("pass", bus.pass, mPass);
            chk("fail", bus.fail, mFail);
            chk("timeout", bus.timeout, mTo);
            chk("done", bus.done, mPass | mFail | mTo);
            chk("store_count", bus.store_count, mCnt);
            chk("trace_count", bus.trace_count, mQ.size());
            chk("trace_ovf", bus.trace_ovf, mOvf);
            chk("trace_valid", bus.trace_valid, mQ.size() > 0);
            if (mQ.size() > 0)
                chk("trace_head", {bus.trace_adr, bus.trace_data}, mQ[0]);
            else
                chk("trace_head_empty", {bus.trace_adr, bus.trace_data}, 64'd0);
        end
    end

    task automatic cyc(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rd);
        bit xb;
        xb = 1'b0;
`ifdef STORE_CHECKER_XCHECK_EN
        xb = $isunknown({a, d});
`endif
        bus.MemWrite = mw; bus.DataAdr = a; bus.WriteData = d; bus.trace_rd = rd;
        @(posedge clk);
        mStep(mw, a, d, rd, xb);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.MemWrite = 0; bus.DataAdr = 0; bus.WriteData = 0; bus.trace_rd = 0;
        mReset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic asyncReset();
        #2 reset = 1'b1;
        mReset();
        #1;
    endtask

    initial begin
        bus.MemWrite = 0; bus.DataAdr = 0; bus.WriteData = 0; bus.trace_rd = 0;
        mReset();
        #1 chkEn = 1'b1;
        doReset();

        // pass sequence with trace readback
        cyc(1, 96, 3, 0);
        cyc(1, 96, 5, 0);
        chk("t1_pass_early", bus.pass, 0);
        cyc(1, 100, 7, 0);
        chk("t1_pass", bus.pass, 1);
        chk("t1_store_count", bus.store_count, 3);
        chk("t1_head0", {bus.trace_adr, bus.trace_data}, {32'd96, 32'd3});
        cyc(1, 80, 1, 1);
        chk("t1_head1", {bus.trace_adr, bus.trace_data}, {32'd96, 32'd5});
        chk("t1_count_frozen", bus.store_count, 3);
        cyc(0, 0, 0, 1);
        chk("t1_head2", {bus.trace_adr, bus.trace_data}, {32'd100, 32'd7});
        cyc(0, 0, 0, 1);
        chk("t1_empty", bus.trace_valid, 0);
        cyc(0, 0, 0, 1);

        // wrong data at pass address
        doReset();
        cyc(1, 100, 6, 0);
        chk("t2_fail", bus.fail, 1);
        chk("t2_nopass", bus.pass, 0);
        cyc(1, 96, 1, 0);
        cyc(1, 100, 7, 0);
        chk("t2_store_count", bus.store_count, 1);

        // disallowed address, later pass store ignored
        doReset();
        cyc(1, 80, 0, 0);
        chk("t3_fail", bus.fail, 1);
        cyc(1, 100, 7, 0);
        chk("t3_still_fail", bus.fail, 1);
        chk("t3_nopass", bus.pass, 0);

        // timeout exactly TO cycles after release
        doReset();
        repeat (TO - 1) cyc(0, 0, 0, 0);
        chk("t4_no_timeout_yet", bus.timeout, 0);
        cyc(0, 0, 0, 0);
        chk("t4_timeout", bus.timeout, 1);
        doReset();
        repeat (TO - 1) cyc(0, 0, 0, 0);
        cyc(1, 100, 7, 0);
        chk("t4_pass_wins", bus.pass, 1);
        chk("t4_timeout_lost", bus.timeout, 0);

        // overflow and push+pop while full
        doReset();
        for (int i = 0; i < 6; i++) cyc(1, 96, i, 0);
        chk("t5_count", bus.trace_count, 4);
        chk("t5_ovf", bus.trace_ovf, 1);
        chk("t5_head", {bus.trace_adr, bus.trace_data}, {32'd96, 32'd0});
        doReset();
        for (int i = 0; i < 4; i++) cyc(1, 96, i, 0);
        cyc(1, 96, 8, 1);
        chk("t5_pp_count", bus.trace_count, 4);
        chk("t5_pp_ovf", bus.trace_ovf, 0);
        chk("t5_pp_head", {bus.trace_adr, bus.trace_data}, {32'd96, 32'd1});

        // asynchronous reset from PASS with data in the FIFO
        doReset();
        cyc(1, 96, 3, 0);
        cyc(1, 100, 7, 0);
        asyncReset();
        chk("t6_pass", bus.pass, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_valid", bus.trace_valid, 0);
        chk("t6_count", bus.trace_count, 0);
        chk("t6_store_count", bus.store_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef STORE_CHECKER_XCHECK_EN
        doReset();
        cyc(1, 'x, 32'd5, 0);
        chk("tx_fail", bus.fail, 1);
        chk("tx_traced", bus.trace_count, 1);
`endif

        // randomized runs
        repeat (30) begin
            doReset();
            repeat (150) begin
                bit mw;
                bit rd;
                logic [31:0] a;
                logic [31:0] d;
                int pick;
                mw = ($urandom_range(0, 99) < 12);
                rd = ($urandom_range(0, 2) == 0);
                pick = $urandom_range(0, 19);
                if (pick == 0) a = 100;
                else if (pick == 1) a = $urandom;
                else a = 96;
                d = $urandom_range(0, 1) ? 32'd7 : $urandom;
                cyc(mw, a, d, rd);
                if ($urandom_range(0, 299) == 0) begin
                    asyncReset();
                    @(posedge clk);
                    #1 reset = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
